// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: default widths, fetch FSM states, PC step.
package riscv_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_ILEN = 32;
  localparam int PC_STEP  = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response and decode handoff.
interface fetch_unit_if
  import riscv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int ILEN = DEF_ILEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous FIFO with registered storage, clear, and simultaneous push/pop when full.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC sequencing, credit-limited imem requests,
// prefetch buffer, and redirect flush that discards in-flight responses.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter int              ILEN     = DEF_ILEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    bus
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e    state, state_nx;
  logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_al;
  logic [CW-1:0]   count, outstanding, outstanding_nx, drop_cnt, drop_nx;
  logic [CW:0]     in_use;
  logic            req_fire, dropping, push, pop, fifo_full, fifo_empty;
  logic [XLEN+ILEN-1:0] fifo_rdata;

  assign redirect_al    = {redirect_pc[XLEN-1:2], 2'b00};
  assign in_use         = {1'b0, count} + {1'b0, outstanding};
  assign bus.imem_req_valid = (state != BOOT) & fetch_en & (in_use < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire       = bus.imem_req_valid & bus.imem_req_ready;
  assign dropping       = (state == FLUSH) && (drop_cnt != '0);
  // Credits already rule out a push into a full FIFO; the full term only keeps the FIFO honest.
  assign push           = bus.imem_rsp_valid & ~dropping & ~redirect_valid & (~fifo_full | pop);
  assign pop            = bus.inst_valid & bus.inst_ready;
  assign outstanding_nx = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);

  always_comb begin
    state_nx = state;
    drop_nx  = drop_cnt;
    case (state)
      BOOT:    state_nx = RUN;
      RUN:     state_nx = RUN;
      FLUSH: begin
        if (dropping && bus.imem_rsp_valid) drop_nx = drop_cnt - 1'b1;
        if (drop_nx == '0) state_nx = RUN;
      end
      default: state_nx = BOOT;
    endcase
    // Redirect counts this cycle's accepted request as in flight; a same-cycle response is discarded.
    if (redirect_valid) begin
      drop_nx  = outstanding_nx;
      state_nx = (outstanding_nx != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nx;
      outstanding <= outstanding_nx;
      drop_cnt    <= drop_nx;
      if (redirect_valid) begin
        fetch_pc <= redirect_al;
        rsp_pc   <= redirect_al;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (push)     rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
      end
    end
  end

  sync_fifo #(
    .WIDTH(XLEN + ILEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({rsp_pc, bus.imem_rsp_data}),
    .rdata (fifo_rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.inst_valid = ~fifo_empty;
  assign bus.inst_pc    = fifo_rdata[XLEN+ILEN-1:ILEN];
  assign bus.inst_data  = fifo_rdata[ILEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with variable latency plus a stream model of
// expected request addresses and delivered {pc, data} pairs.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int          XLEN   = 32;
  localparam int          ILEN   = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  fetch_unit #(
    .XLEN    (XLEN),
    .ILEN    (ILEN),
    .DEPTH   (DEPTH),
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       memq[$];
  int unsigned cyc = 0, lat = 1, last_due = 0;
  int unsigned ready_pct = 100;
  int unsigned n_req = 0, n_pop = 0, n_rsp = 0;
  logic [31:0] exp_req, exp_pc, last_pop_pc, last_req_addr;
  bit          saw_wrap;
  int          vectors = 0, miscompares = 0;

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    last_due = 0;
    exp_req  = RST_PC;
    exp_pc   = RST_PC;
    redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
  endtask

  // One clock: entered just after a falling edge, returns at the next falling edge.
  task automatic cycle();
    logic        req_fire, pop_fire;
    mreq_t       r;
    int unsigned due;
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      r = memq.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_data(r.addr);
      n_rsp++;
    end
    #1;
    req_fire = bus.imem_req_valid && bus.imem_req_ready;
    pop_fire = bus.inst_valid && bus.inst_ready;
    if (req_fire) begin
      check("req_addr", bus.imem_req_addr, exp_req);
      if (last_req_addr == 32'hFFFF_FFFC && bus.imem_req_addr == 32'h0) saw_wrap = 1'b1;
      last_req_addr = bus.imem_req_addr;
      exp_req = exp_req + 32'd4;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{bus.imem_req_addr, due});
      n_req++;
    end
    if (pop_fire) begin
      check("inst_pc", bus.inst_pc, exp_pc);
      check("inst_data", bus.inst_data, mem_data(exp_pc));
      last_pop_pc = bus.inst_pc;
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    if (redirect_valid) begin
      exp_req = {redirect_pc[31:2], 2'b00};
      exp_pc  = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r0, p0, rs0, k, exp_drop;
    reset = 1'b1;
    fetch_en = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.inst_ready = 1'b1;
    bus.imem_req_ready = 1'b1;
    last_req_addr = '0;
    saw_wrap = 1'b0;
    last_pop_pc = '0;
    model_reset();
    repeat (2) @(negedge clk);

    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_inst_valid", bus.inst_valid, 0);
    check("rst_req_addr", bus.imem_req_addr, RST_PC);
    check("rst_inst_data", bus.inst_data, 0);
    check("rst_inst_pc", bus.inst_pc, 0);
    reset = 1'b0;
    check("boot_no_req", bus.imem_req_valid, 0);

    // Latency-1 streaming: one instruction per cycle once filled.
    lat = 1; ready_pct = 100;
    repeat (3) cycle();
    check("first_req_seen", n_req, 2);
    p0 = n_pop;
    repeat (16) cycle();
    check("throughput", n_pop - p0, 16);

    // Back-pressure: DEPTH requests then stall; one pop frees one request.
    restart();
    bus.inst_ready = 1'b0;
    r0 = n_req;
    repeat (12) cycle();
    check("full_reqs", n_req - r0, DEPTH);
    check("req_valid_stall", bus.imem_req_valid, 0);
    bus.inst_ready = 1'b1;
    p0 = n_pop;
    cycle();
    check("single_pop", n_pop - p0, 1);
    bus.inst_ready = 1'b0;
    r0 = n_req;
    repeat (8) cycle();
    check("one_more_req", n_req - r0, 1);
    bus.inst_ready = 1'b1;
    repeat (8) cycle();

    // Latency-3 redirect with three requests in flight.
    restart();
    lat = 3;
    r0 = n_req;
    k = 0;
    while (n_req - r0 < 2 && k < 20) begin cycle(); k++; end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2003;
    cycle();
    check("req_with_redirect", n_req - r0, 3);
    exp_drop = memq.size();
    check("lat3_inflight", exp_drop, 3);
    rs0 = n_rsp;
    k = 0;
    while (!bus.inst_valid && k < 40) begin cycle(); k++; end
    check("lat3_valid_seen", bus.inst_valid, 1);
    check("lat3_dropped", n_rsp - rs0, exp_drop + 1);
    cycle();
    check("lat3_first_pc", last_pop_pc, 32'h0000_2000);

    // Redirect coinciding with both a request and a response handshake.
    restart();
    lat = 2;
    repeat (8) cycle();
    r0 = n_req;
    rs0 = n_rsp;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    cycle();
    check("same_cycle_req", n_req - r0, 1);
    check("same_cycle_rsp", n_rsp - rs0, 1);
    exp_drop = memq.size();
    rs0 = n_rsp;
    k = 0;
    while (!bus.inst_valid && k < 40) begin cycle(); k++; end
    check("same_cycle_valid_seen", bus.inst_valid, 1);
    check("same_cycle_dropped", n_rsp - rs0, exp_drop + 1);
    cycle();
    check("same_cycle_first_pc", last_pop_pc, 32'h0000_3000);

    // fetch_en low with two in flight.
    restart();
    lat = 3;
    r0 = n_req;
    k = 0;
    while (n_req - r0 < 2 && k < 20) begin cycle(); k++; end
    fetch_en = 1'b0;
    r0 = n_req;
    p0 = n_pop;
    repeat (10) cycle();
    check("fetch_en_no_req", n_req - r0, 0);
    check("fetch_en_pops", n_pop - p0, 2);
    check("fetch_en_last_pc", last_pop_pc, RST_PC + 32'd4);
    fetch_en = 1'b1;

    // PC wrap at the top of the address space.
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cycle();
    repeat (12) cycle();
    check("pc_wrap", saw_wrap, 1);

    // Reset asserted while flushing.
    lat = 4;
    repeat (6) cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_4000;
    cycle();
    #2;
    reset = 1'b1;
    #1;
    check("midflush_req_valid", bus.imem_req_valid, 0);
    check("midflush_inst_valid", bus.inst_valid, 0);
    check("midflush_req_addr", bus.imem_req_addr, RST_PC);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    lat = 1;
    p0 = n_pop;
    k = 0;
    while (n_pop == p0 && k < 20) begin cycle(); k++; end
    check("restart_first_pc", last_pop_pc, RST_PC);

    // Randomised traffic against the stream model.
    restart();
    ready_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      lat = $urandom_range(4, 1);
      bus.inst_ready = ($urandom_range(99) < 70);
      fetch_en = ($urandom_range(99) < 90);
      if ($urandom_range(99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end that replaces the single-cycle PC register / PC+4 / branch-mux path. Holds the fetch PC, issues in-order requests to an instruction memory with a valid/ready handshake and variable response latency, buffers returned instructions with their PCs in a prefetch FIFO, and hands them to decode over a valid/ready interface. Branch/jump redirects from execute flush the buffer and discard in-flight responses.

## Interface
- XLEN, 32: address and PC width.
- ILEN, 32: instruction width.
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2. Also bounds requests in flight.
- RESET_PC, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_en  in  1  when low, no new requests; in-flight responses still complete.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; in request order; cannot be back-pressured.
- imem_rsp_data  in  ILEN  instruction word.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  ILEN  head instruction.
- inst_pc  out  XLEN  PC of head instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (forced 0).

## Operation
- State: fetch_pc, rsp_pc, FIFO (entries {pc, inst}), count, outstanding, drop_cnt, FSM.
- FSM states: BOOT, RUN, FLUSH.
  - BOOT: entered on reset; no requests; next cycle → RUN.
  - RUN: normal. redirect_valid → FLUSH if requests remain in flight after this cycle, else stay RUN.
  - FLUSH: first drop_cnt responses discarded; requests may be issued. drop_cnt reaching 0 → RUN. Further redirect reloads drop_cnt.
- credits = DEPTH − count − outstanding. Width of count/outstanding/drop_cnt: $clog2(DEPTH+1).
- imem_req_valid = (state ≠ BOOT) & fetch_en & (credits > 0). It depends on registered state only, not on redirect_valid.
- Request handshake: fetch_pc += 4, modulo 2^XLEN, wrapping silently; outstanding += 1.
- Response in RUN, or in FLUSH with drop_cnt = 0: push {rsp_pc, data}; rsp_pc += 4; outstanding −= 1. Credits guarantee the FIFO is never pushed when full.
- Response while dropping: discarded; drop_cnt −= 1; outstanding −= 1.
- Pop on inst_valid & inst_ready.
- Redirect cycle:
  - FIFO cleared.
  - fetch_pc and rsp_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt ← outstanding after this cycle's request and response handshakes. A request accepted this cycle counts as in flight; a response arriving this cycle is discarded and not counted.
  - A decode handshake in the redirect cycle is honoured.

## Timing
- Reset values: imem_req_valid 0, inst_valid 0, imem_req_addr = RESET_PC, inst_data 0, inst_pc 0, count/outstanding/drop_cnt 0, state BOOT.
- First request: the cycle after reset deasserts with fetch_en=1; address RESET_PC.
- Zero-latency memory (response the cycle after acceptance): sustained throughput of 1 instruction/cycle.
- Response → inst_valid: 1 cycle, because the FIFO is registered. No combinational path from imem_rsp_* or redirect_* to any output.
- FIFO full with simultaneous pop and push: both occur; count unchanged.
- After a redirect, the first instruction delivered has inst_pc = redirect_pc. No stale instruction is ever presented.
- Reset asserted mid-operation: all state cleared immediately. Responses arriving after reset are the memory's responsibility; memory must also be reset.

## Structure
- Shared riscv_pkg:
  - XLEN and ILEN defaults.
  - Fetch FSM state enum (BOOT, RUN, FLUSH).
  - Constant PC_STEP = 4.
- Sub-module sync_fifo: parametrised width and depth, with clear, push, pop, count, full and empty.
- fetch_unit instantiates sync_fifo with width XLEN+ILEN and holds the counters and FSM.

## Test plan
- Reset with RESET_PC=0x100, always-ready memory with latency 1, inst_ready=1: requests 0x100, 0x104, …; decode sees inst_pc 0x100, 0x104, … one per cycle after fill.
- inst_ready=0 with DEPTH=4: exactly 4 requests are issued, then imem_req_valid stays 0. Raising inst_ready for one cycle pops one entry and issues exactly one new request.
- Latency-3 memory with 3 requests in flight, redirect_pc=0x2003: the next 3 responses are dropped; the first delivered entry has inst_pc 0x2000 with the data for address 0x2000.
- Redirect in the same cycle as both a request handshake and a response: the response is discarded, the request is counted, and drop_cnt = 1 + prior in-flight count.
- fetch_en deasserted with 2 in flight: no new requests; both responses land; inst_pc values are consecutive.
- fetch_pc = 0xFFFF_FFFC wraps to 0x0000_0000 on the next request. Reset asserted mid-FLUSH: inst_valid=0 and imem_req_valid=0 immediately; restart at RESET_PC.
